// File: rtl/pid_loop_scheduler_if.sv
// ADC / PID handshake bundle for pid_loop_scheduler.
// master is the scheduler side; slave is the ADC + PID controller side.
interface pid_loop_scheduler_if;
    logic               adc_req;
    logic               adc_ack;
    logic [15:0]        adc_data;
    logic [15:0]        pressure_out;
    logic               pid_tick;
    logic signed [15:0] pid_in;
    logic signed [15:0] cmd_out;
    logic               cmd_valid;

    modport master (
        output adc_req, pressure_out, pid_tick, cmd_out, cmd_valid,
        input  adc_ack, adc_data, pid_in
    );

    modport slave (
        input  adc_req, pressure_out, pid_tick, cmd_out, cmd_valid,
        output adc_ack, adc_data, pid_in
    );
endinterface

// File: rtl/pid_loop_scheduler.sv
// Sample-rate sequencer: ADC request -> pressure capture -> PID tick -> settle -> command latch.
// Optional ADC watchdog enabled by defining PID_SCHED_WATCHDOG_EN.
module pid_loop_scheduler #(
    parameter int unsigned SAMPLE_DIV    = 100000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ADC_TIMEOUT   = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clr_flags,
    pid_loop_scheduler_if.master    bus,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout
);
    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_TICK   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               sample_due_s;
    logic [7:0]         settle_r, settle_s;
    logic               adc_req_r, adc_req_s;
    logic               pid_tick_r, pid_tick_s;
    logic               cmd_valid_r, cmd_valid_s;
    logic               busy_r, busy_s;
    logic               overrun_r, overrun_s;
    logic [15:0]        pressure_r, pressure_s;
    logic signed [15:0] cmd_r, cmd_s;
    logic               timeout_set_s;

    assign sample_due_s = enable && (cnt_r == DIV_LAST);

    // Sample-period counter, parked at zero while the loop is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!enable || sample_due_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

`ifdef PID_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(ADC_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ADC_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_r, timeout_s;

    // Cycles spent waiting in REQ; restarts on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r  <= {WD_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            wd_cnt_r  <= (state_r == ST_REQ) ? (wd_cnt_r + WD_W'(1)) : {WD_W{1'b0}};
            timeout_r <= timeout_s;
        end
    end

    // Sticky timeout: a set in the same cycle as a clear takes priority
    always_comb begin
        timeout_s = timeout_r;
        if (timeout_set_s) begin
            timeout_s = 1'b1;
        end else if (clr_flags) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Next state and next values of every registered output
    always_comb begin
        state_s       = state_r;
        settle_s      = settle_r;
        adc_req_s     = 1'b0;
        pid_tick_s    = 1'b0;
        cmd_valid_s   = 1'b0;
        pressure_s    = pressure_r;
        cmd_s         = cmd_r;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sample_due_s) begin
                    state_s   = ST_REQ;
                    adc_req_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.adc_ack) begin
                    pressure_s = bus.adc_data;
                    pid_tick_s = 1'b1;
                    state_s    = ST_TICK;
                end
`ifdef PID_SCHED_WATCHDOG_EN
                else if (wd_cnt_r == WD_LAST) begin
                    timeout_set_s = 1'b1;
                    state_s       = ST_IDLE;
                end
`endif
                else begin
                    adc_req_s = 1'b1;
                end
            end
            ST_TICK: begin
                settle_s = 8'd0;
                state_s  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_r == SETTLE_LAST) begin
                    cmd_s       = bus.pid_in;
                    cmd_valid_s = 1'b1;
                    state_s     = ST_LATCH;
                end else begin
                    settle_s    = settle_r + 8'd1;
                end
            end
            ST_LATCH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // Sticky overrun: a sample falling due mid-sequence is dropped and flagged
    always_comb begin
        overrun_s = overrun_r;
        if (sample_due_s && (state_r != ST_IDLE)) begin
            overrun_s = 1'b1;
        end else if (clr_flags) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            settle_r    <= 8'd0;
            adc_req_r   <= 1'b0;
            pid_tick_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            pressure_r  <= 16'd0;
            cmd_r       <= 16'sd0;
        end else begin
            state_r     <= state_s;
            settle_r    <= settle_s;
            adc_req_r   <= adc_req_s;
            pid_tick_r  <= pid_tick_s;
            cmd_valid_r <= cmd_valid_s;
            busy_r      <= busy_s;
            overrun_r   <= overrun_s;
            pressure_r  <= pressure_s;
            cmd_r       <= cmd_s;
        end
    end

    assign bus.adc_req      = adc_req_r;
    assign bus.pid_tick     = pid_tick_r;
    assign bus.cmd_valid    = cmd_valid_r;
    assign bus.pressure_out = pressure_r;
    assign bus.cmd_out      = cmd_r;
    assign busy             = busy_r;
    assign overrun          = overrun_r;
endmodule

// File: doc/pid_loop_scheduler.md
PID_LOOP_SCHEDULER -- requirements
Module: pid_loop_scheduler

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000, SHALL be the number of CLK cycles per control sample period (legal range 16..2^24).
REQ-002 Parameter SETTLE_CYCLES, default 4, SHALL be the number of CLK cycles waited between PID_TICK and capture of PID_IN (legal range 2..255).
REQ-003 Parameter ADC_TIMEOUT, default 1000, SHALL be the number of CLK cycles ADC_REQ may wait for ADC_ACK (used only with the watchdog).
REQ-004 Port CLK, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-006 ENABLE, input, 1: when high, the loop runs.
REQ-007 CLR_FLAGS, input, 1: clears the sticky flags.
REQ-008 ADC_REQ, output, 1: conversion request to the pressure ADC.
REQ-009 ADC_ACK, input, 1: conversion done; ADC_DATA is valid in the same cycle.
REQ-010 ADC_DATA, input, 16: unsigned pressure sample.
REQ-011 PRESSURE_OUT, output, 16: latched pressure that drives the PID current-value input.
REQ-012 PID_TICK, output, 1: sample strobe that drives the PID sample input.
REQ-013 PID_IN, input, 16 signed: PID controller output.
REQ-014 CMD_OUT, output, 16 signed: latched actuator command.
REQ-015 CMD_VALID, output, 1: one-cycle pulse marking an update of CMD_OUT.
REQ-016 BUSY, output, 1: high in any state other than IDLE.
REQ-017 OVERRUN, output, 1: sticky flag; a sample was due while a sequence was still active.
REQ-018 TIMEOUT, output, 1: sticky flag; an ADC request timed out.

Function
REQ-019 The sample counter SHALL count 0..SAMPLE_DIV-1 and wrap while ENABLE=1, and SHALL be held at 0 while ENABLE=0.
REQ-020 sample_due SHALL be asserted in the cycle the counter equals SAMPLE_DIV-1; the first sample_due therefore occurs SAMPLE_DIV cycles after ENABLE rises.
REQ-021 The FSM SHALL have the states IDLE, REQ, TICK, SETTLE and LATCH, and all outputs SHALL be registered.
REQ-022 IDLE: on sample_due the FSM SHALL go to REQ, and ADC_REQ SHALL be high starting the next cycle.
REQ-023 REQ: ADC_REQ SHALL stay high until ADC_ACK is sampled high. On that edge PRESSURE_OUT SHALL take ADC_DATA, ADC_REQ SHALL drop, and the FSM SHALL go to TICK. ADC_ACK SHALL be ignored outside REQ.
REQ-024 TICK: PID_TICK SHALL be high for exactly one cycle while PRESSURE_OUT is stable; the FSM then goes to SETTLE.
REQ-025 SETTLE: the FSM SHALL wait SETTLE_CYCLES cycles, then go to LATCH.
REQ-026 LATCH: CMD_OUT SHALL take PID_IN, CMD_VALID SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-027 If sample_due occurs while the FSM is not in IDLE, OVERRUN SHALL set, that sample SHALL be dropped, and the current sequence SHALL continue unaffected.
REQ-028 If ENABLE falls mid-sequence, the sequence in flight SHALL complete to IDLE, and no new sequence SHALL start.
REQ-029 CLR_FLAGS SHALL clear OVERRUN and TIMEOUT; if a set and CLR_FLAGS occur in the same cycle, the set SHALL win.
REQ-030 PRESSURE_OUT and CMD_OUT SHALL hold their values between updates; no arithmetic is applied, only capture.

Reset
REQ-031 While RESET_N=0, independent of CLK: FSM=IDLE, all counters 0, and ADC_REQ, PID_TICK, CMD_VALID, BUSY, OVERRUN, TIMEOUT, PRESSURE_OUT and CMD_OUT all 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately. After release, the first sequence SHALL start only at the next sample_due.

Configuration
REQ-033 Macro PID_SCHED_WATCHDOG_EN defined: a REQ-state cycle counter SHALL run. If ADC_TIMEOUT cycles elapse in REQ with no ADC_ACK, then ADC_REQ SHALL drop, TIMEOUT SHALL set, PRESSURE_OUT SHALL be unchanged, no PID_TICK SHALL be issued, and the FSM SHALL go to IDLE. An ADC_ACK in the timeout cycle SHALL win over the timeout.
REQ-034 Macro PID_SCHED_WATCHDOG_EN undefined: REQ SHALL wait for ADC_ACK indefinitely, TIMEOUT SHALL be constant 0, and no watchdog logic SHALL be present.

Verification
REQ-035 Test parameters: SAMPLE_DIV=20, SETTLE_CYCLES=4, ADC_TIMEOUT=8.
- Nominal: ENABLE=1 with ADC_ACK 3 cycles after ADC_REQ, ADC_DATA=950 -> PRESSURE_OUT=950, then a 1-cycle PID_TICK, then CMD_VALID 4 cycles later with CMD_OUT equal to PID_IN (-123); the sequence repeats every 20 cycles.
- Overrun: ADC_ACK delayed 25 cycles -> OVERRUN=1, exactly one PID_TICK per completed sequence, next sequence at the following sample_due.
- Watchdog (macro defined): no ADC_ACK -> ADC_REQ drops after 8 cycles, TIMEOUT=1, no PID_TICK, PRESSURE_OUT unchanged; CLR_FLAGS -> TIMEOUT=0. Same stimulus with the macro undefined -> ADC_REQ stays high and TIMEOUT stays 0.
- Mid-sequence: ENABLE=0 during SETTLE -> CMD_VALID still pulses once, then no further ADC_REQ. RESET_N=0 during REQ -> all outputs 0 immediately.
- Flag race: CLR_FLAGS in the same cycle as an overrun event -> OVERRUN=1.
